// File: rtl/pp_buf_ctrl.sv
// Ping-pong buffer controller: fills one RAM bank while bursting the other out.
// Define PP_BUF_CTRL_AUTO_START_EN to start each burst automatically (rd_start ignored).
module pp_buf_ctrl #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W:0]   len,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    input  logic              rd_start,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              out_valid,
    output logic              out_last,
    output logic              rd_avail,
    output logic              switch
);

    localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];
    localparam int              DW      = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int              DLAST_I = (RD_LAT > 0) ? RD_LAT - 1 : 0;
    localparam logic [DW-1:0]   DLAST   = DLAST_I[DW-1:0];

    typedef enum logic {
        W_FILL,
        W_FULL
    } wstate_t;

    typedef enum logic [1:0] {
        R_EMPTY,
        R_READY,
        R_BURST,
        R_DRAIN
    } rstate_t;

    wstate_t         wstate, wstate_nx;
    rstate_t         rstate, rstate_nx;
    logic [ADDR_W:0] count, count_nx;
    logic [ADDR_W:0] wlen, wlen_nx;
    logic [ADDR_W:0] rlen, rlen_nx;
    logic [ADDR_W:0] raddr, raddr_nx;
    logic [DW-1:0]   dcnt, dcnt_nx;

    logic            swap;
    logic            fill_open;
    logic            wr_fire;
    logic [ADDR_W:0] fill_len;
    logic            issue;
    logic            last_issue;
    logic            start_req;

`ifdef PP_BUF_CTRL_AUTO_START_EN
    logic unused_rd_start;
    assign unused_rd_start = rd_start;
    assign start_req       = 1'b1;
`else
    assign start_req       = rd_start;
`endif

    assign swap       = (wstate == W_FULL) && (rstate == R_EMPTY);
    assign fill_open  = (wstate == W_FILL);
    assign wr_fire    = in_valid && fill_open;
    assign issue      = (rstate == R_BURST);
    assign last_issue = issue && (raddr == rlen - 1'b1);

    // Fill length is captured on the first word; out-of-range requests mean a full bank.
    always_comb begin
        fill_len = wlen;
        if (count == '0) begin
            if (len == '0 || len > DEPTH_W) begin
                fill_len = DEPTH_W;
            end else begin
                fill_len = len;
            end
        end
    end

    always_comb begin
        wstate_nx = wstate;
        count_nx  = count;
        wlen_nx   = wlen;
        case (wstate)
            W_FILL: begin
                if (wr_fire) begin
                    wlen_nx  = fill_len;
                    count_nx = count + 1'b1;
                    if (count + 1'b1 == fill_len) begin
                        wstate_nx = W_FULL;
                    end
                end
            end
            W_FULL: begin
                if (swap) begin
                    wstate_nx = W_FILL;
                    count_nx  = '0;
                end
            end
            default: wstate_nx = W_FILL;
        endcase
    end

    // The drain phase lets the last RD_LAT words emerge before the banks may swap again.
    always_comb begin
        rstate_nx = rstate;
        rlen_nx   = rlen;
        raddr_nx  = raddr;
        dcnt_nx   = dcnt;
        case (rstate)
            R_EMPTY: begin
                if (swap) begin
                    rstate_nx = R_READY;
                    rlen_nx   = wlen;
                end
            end
            R_READY: begin
                if (start_req) begin
                    rstate_nx = R_BURST;
                    raddr_nx  = '0;
                end
            end
            R_BURST: begin
                raddr_nx = raddr + 1'b1;
                if (last_issue) begin
                    raddr_nx  = '0;
                    dcnt_nx   = '0;
                    rstate_nx = (RD_LAT == 0) ? R_EMPTY : R_DRAIN;
                end
            end
            R_DRAIN: begin
                dcnt_nx = dcnt + 1'b1;
                if (dcnt == DLAST) begin
                    rstate_nx = R_EMPTY;
                end
            end
            default: rstate_nx = R_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate <= W_FILL;
            count  <= '0;
            wlen   <= '0;
            rstate <= R_EMPTY;
            rlen   <= '0;
            raddr  <= '0;
            dcnt   <= '0;
        end else begin
            wstate <= wstate_nx;
            count  <= count_nx;
            wlen   <= wlen_nx;
            rstate <= rstate_nx;
            rlen   <= rlen_nx;
            raddr  <= raddr_nx;
            dcnt   <= dcnt_nx;
        end
    end

    assign in_ready = fill_open & ~rst;
    assign wr_en    = in_valid & in_ready;
    assign wr_addr  = in_ready ? count[ADDR_W-1:0] : '0;
    assign rd_addr  = (issue && !rst) ? raddr[ADDR_W-1:0] : '0;
    assign rd_avail = (rstate == R_READY) & ~rst;
    assign switch   = swap & ~rst;

    // Address strobe and last-flag travel alongside the RAM read latency.
    generate
        if (RD_LAT == 0) begin : g_nopipe
            assign out_valid = issue & ~rst;
            assign out_last  = last_issue & ~rst;
        end else begin : g_pipe
            logic [RD_LAT-1:0] vpipe;
            logic [RD_LAT-1:0] lpipe;

            always_ff @(posedge clk) begin
                if (rst) begin
                    vpipe <= '0;
                    lpipe <= '0;
                end else begin
                    vpipe[0] <= issue;
                    lpipe[0] <= last_issue;
                    for (int i = 1; i < RD_LAT; i++) begin
                        vpipe[i] <= vpipe[i-1];
                        lpipe[i] <= lpipe[i-1];
                    end
                end
            end

            assign out_valid = vpipe[RD_LAT-1] & ~rst;
            assign out_last  = lpipe[RD_LAT-1] & ~rst;
        end
    endgenerate

endmodule

// File: tb/tb_pp_buf_ctrl.sv
// Directed bench for pp_buf_ctrl; expectations are hand-timed per cycle.
// Flags are packed as {in_ready, wr_en, switch, rd_avail, out_valid, out_last}.
module tb_pp_buf_ctrl;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;
    localparam int RD_LAT = 2;

    logic              clk;
    logic              rst;
    logic [ADDR_W:0]   len;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              rd_start;
    logic [ADDR_W-1:0] rd_addr;
    logic              out_valid;
    logic              out_last;
    logic              rd_avail;
    logic              switch;
    logic [5:0]        flags;

    int n_cmp;
    int n_bad;

    pp_buf_ctrl #(
        .DEPTH (DEPTH),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .len      (len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rd_start (rd_start),
        .rd_addr  (rd_addr),
        .out_valid(out_valid),
        .out_last (out_last),
        .rd_avail (rd_avail),
        .switch   (switch)
    );

    assign flags = {in_ready, wr_en, switch, rd_avail, out_valid, out_last};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst      = 1'b1;
        in_valid = 1'b0;
        rd_start = 1'b0;
        len      = 9'd4;
        next_cycle;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        in_valid = 1'b1;
        rd_start = 1'b1;
        len      = 9'd4;
        next_cycle;
        next_cycle;
        #4;
        n_cmp++;
        if (flags !== 6'b000000 || wr_addr !== '0 || rd_addr !== '0) begin
            n_bad++;
            $display("[TB] FAIL reset_outputs: flags got %b want 000000, wr_addr %0d rd_addr %0d want 0",
                     flags, wr_addr, rd_addr);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (flags !== 6'b110000 || wr_addr !== '0) begin
            n_bad++;
            $display("[TB] FAIL reset_release: flags got %b want 110000, wr_addr got %0d want 0",
                     flags, wr_addr);
        end
        in_valid = 1'b0;
        rd_start = 1'b0;
        next_cycle;
    endtask

    task automatic test_fill_switch;
        logic [5:0] exp;
        do_reset;
        for (int c = 0; c < 6; c++) begin
            in_valid = (c <= 4);
            #4;
            if (c < 4)       exp = 6'b110000;
            else if (c == 4) exp = 6'b001000;
            else             exp = 6'b100100;
            n_cmp++;
            if (flags !== exp) begin
                n_bad++;
                $display("[TB] FAIL fill_switch_flags c=%0d: got %b want %b", c, flags, exp);
            end
            if (c < 4) begin
                n_cmp++;
                if (wr_addr !== ADDR_W'(c)) begin
                    n_bad++;
                    $display("[TB] FAIL fill_switch_wr_addr c=%0d: got %0d want %0d", c, wr_addr, c);
                end
            end
            next_cycle;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_burst;
        logic [5:0]        exp;
        logic [ADDR_W-1:0] exp_ra;
        do_reset;
        for (int c = 0; c < 5; c++) begin
            in_valid = (c < 4);
            next_cycle;
        end
        in_valid = 1'b0;
        for (int c = 0; c < 9; c++) begin
            rd_start = (c == 0 || c == 2 || c == 7);
            #4;
            exp    = {1'b1, 1'b0, 1'b0, c == 0, c >= 3 && c <= 6, c == 6};
            exp_ra = (c >= 1 && c <= 4) ? ADDR_W'(c - 1) : '0;
            n_cmp++;
            if (flags !== exp || rd_addr !== exp_ra) begin
                n_bad++;
                $display("[TB] FAIL burst c=%0d: flags got %b want %b, rd_addr got %0d want %0d",
                         c, flags, exp, rd_addr, exp_ra);
            end
            next_cycle;
        end
        rd_start = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [5:0]        exp;
        logic              ir;
        logic [ADDR_W-1:0] exp_ra;
        logic [ADDR_W-1:0] exp_wa;
        do_reset;
        for (int c = 0; c < 14; c++) begin
            in_valid = 1'b1;
            rd_start = (c == 5);
            #4;
            ir     = (c <= 3) || (c >= 5 && c <= 8) || (c == 13);
            exp    = {ir, ir, c == 4 || c == 12, c == 5 || c == 13, c >= 8 && c <= 11, c == 11};
            exp_ra = (c >= 6 && c <= 9) ? ADDR_W'(c - 6) : '0;
            if (c <= 3)                exp_wa = ADDR_W'(c);
            else if (c >= 5 && c <= 8) exp_wa = ADDR_W'(c - 5);
            else                       exp_wa = '0;
            n_cmp++;
            if (flags !== exp || rd_addr !== exp_ra) begin
                n_bad++;
                $display("[TB] FAIL back_to_back c=%0d: flags got %b want %b, rd_addr got %0d want %0d",
                         c, flags, exp, rd_addr, exp_ra);
            end
            if (ir) begin
                n_cmp++;
                if (wr_addr !== exp_wa) begin
                    n_bad++;
                    $display("[TB] FAIL back_to_back_wr_addr c=%0d: got %0d want %0d", c, wr_addr, exp_wa);
                end
            end
            next_cycle;
        end
        in_valid = 1'b0;
        rd_start = 1'b0;
    endtask

    task automatic test_len_limits;
        logic [ADDR_W:0] lens [2];
        lens[0] = 9'd0;
        lens[1] = 9'd300;
        for (int k = 0; k < 2; k++) begin
            do_reset;
            for (int i = 0; i <= DEPTH; i++) begin
                len      = (i == 0) ? lens[k] : 9'd5;
                in_valid = 1'b1;
                #4;
                n_cmp++;
                if (i < DEPTH) begin
                    if (flags !== 6'b110000 || wr_addr !== i[ADDR_W-1:0]) begin
                        n_bad++;
                        $display("[TB] FAIL len_limit len=%0d word=%0d: flags got %b want 110000, wr_addr got %0d want %0d",
                                 lens[k], i, flags, wr_addr, i[ADDR_W-1:0]);
                    end
                end else begin
                    if (flags !== 6'b001000) begin
                        n_bad++;
                        $display("[TB] FAIL len_limit_full len=%0d: flags got %b want 001000", lens[k], flags);
                    end
                end
                next_cycle;
            end
        end
        do_reset;
        for (int c = 0; c < 5; c++) begin
            len      = (c == 0) ? 9'd4 : 9'd8;
            in_valid = 1'b1;
            #4;
            n_cmp++;
            if (c < 4) begin
                if (flags !== 6'b110000 || wr_addr !== ADDR_W'(c)) begin
                    n_bad++;
                    $display("[TB] FAIL len_change c=%0d: flags got %b want 110000, wr_addr got %0d want %0d",
                             c, flags, wr_addr, c);
                end
            end else begin
                if (flags !== 6'b001000) begin
                    n_bad++;
                    $display("[TB] FAIL len_change_full: flags got %b want 001000", flags);
                end
            end
            next_cycle;
        end
        in_valid = 1'b0;
        len      = 9'd4;
    endtask

    task automatic test_reset_mid_burst;
        do_reset;
        for (int c = 0; c < 11; c++) begin
            in_valid = (c <= 8);
            rd_start = (c == 5);
            rst      = (c == 8);
            #4;
            if (c == 7) begin
                n_cmp++;
                if (rd_addr !== 8'd1) begin
                    n_bad++;
                    $display("[TB] FAIL pre_reset_rd_addr: got %0d want 1", rd_addr);
                end
            end
            if (c == 8) begin
                n_cmp++;
                if (flags !== 6'b000000 || wr_addr !== '0 || rd_addr !== '0) begin
                    n_bad++;
                    $display("[TB] FAIL mid_burst_rst_outputs: flags got %b want 000000, wr_addr %0d rd_addr %0d want 0",
                             flags, wr_addr, rd_addr);
                end
            end
            if (c >= 9) begin
                n_cmp++;
                if (flags !== 6'b100000) begin
                    n_bad++;
                    $display("[TB] FAIL after_mid_burst_rst c=%0d: flags got %b want 100000", c, flags);
                end
            end
            next_cycle;
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        rd_start = 1'b0;
    endtask

    task automatic test_start_mode;
        logic [5:0]        exp;
        logic [ADDR_W-1:0] exp_ra;
        logic              ir;
        do_reset;
        for (int c = 0; c < 12; c++) begin
            in_valid = (c < 4);
            rd_start = 1'b0;
            #4;
            ir = (c != 4);
`ifdef PP_BUF_CTRL_AUTO_START_EN
            exp    = {ir, c < 4, c == 4, c == 5, c >= 8 && c <= 11, c == 11};
            exp_ra = (c >= 6 && c <= 9) ? ADDR_W'(c - 6) : '0;
`else
            exp    = {ir, c < 4, c == 4, c >= 5, 1'b0, 1'b0};
            exp_ra = '0;
`endif
            n_cmp++;
            if (flags !== exp || rd_addr !== exp_ra) begin
                n_bad++;
                $display("[TB] FAIL start_mode c=%0d: flags got %b want %b, rd_addr got %0d want %0d",
                         c, flags, exp, rd_addr, exp_ra);
            end
            next_cycle;
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst      = 1'b1;
        len      = 9'd4;
        in_valid = 1'b0;
        rd_start = 1'b0;
        $display("[TB] pp_buf_ctrl directed run starting");
        test_reset;
        test_fill_switch;
        test_burst;
        test_back_to_back;
        test_len_limits;
        test_reset_mid_burst;
        test_start_mode;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pp_buf_ctrl.md
PP_BUF_CTRL -- requirements
Module: pp_buf_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning words per bank of the attached ping-pong RAM.
REQ-002 The block SHALL have parameter ADDR_W, default bw(DEPTH), meaning bank address width; it is derived and not overridden.
REQ-003 The block SHALL have parameter RD_LAT, default 2, meaning RAM read latency in cycles from rd_addr to valid rd_data.
REQ-004 The block SHALL have one clock and reset: clk, input, 1 bit, the single clock; rst, input, 1 bit, synchronous, active-high.
REQ-005 The block SHALL have port len, input, ADDR_W+1 bits, meaning words per fill/burst.
REQ-006 The block SHALL have port in_valid, input, 1 bit, meaning producer word available.
REQ-007 The block SHALL have port in_ready, output, 1 bit, meaning write bank accepting.
REQ-008 The block SHALL have port wr_en, output, 1 bit, equal to in_valid & in_ready.
REQ-009 The block SHALL have port wr_addr, output, ADDR_W bits, meaning write-bank address.
REQ-010 The block SHALL have port rd_start, input, 1 bit, meaning consumer burst request.
REQ-011 The block SHALL have port rd_addr, output, ADDR_W bits, meaning read-bank address.
REQ-012 The block SHALL have port out_valid, output, 1 bit, meaning the RAM's rd_data is valid this cycle.
REQ-013 The block SHALL have port out_last, output, 1 bit, meaning the last word of the burst.
REQ-014 The block SHALL have port rd_avail, output, 1 bit, meaning the read bank holds unread data.
REQ-015 The block SHALL have port switch, output, 1 bit, a one-cycle bank swap pulse to the RAM.

Function
REQ-016 The write FSM SHALL have states W_FILL and W_FULL.
REQ-017 The read FSM SHALL have states R_EMPTY, R_READY, R_BURST and R_DRAIN.
REQ-018 On the first accepted word of a fill (count 0), len SHALL be latched as wlen; a len of 0 or a len greater than DEPTH SHALL be latched as DEPTH; changes to len mid-fill SHALL be ignored.
REQ-019 In W_FILL, in_ready SHALL be 1; each wr_en SHALL write at wr_addr = count and then increment count.
REQ-020 The write that makes count equal to wlen SHALL move the write FSM to W_FULL, with in_ready=0 from the next cycle.
REQ-021 switch SHALL be 1, combinationally, exactly in cycles where W_FULL and R_EMPTY hold.
REQ-022 On a switch edge: the write FSM SHALL go to W_FILL with count=0; rlen SHALL take wlen; the read FSM SHALL go to R_READY.
REQ-023 The first write after a switch SHALL occur no earlier than the cycle after the switch.
REQ-024 rd_avail SHALL be 1 only in R_READY.
REQ-025 In R_READY, rd_start SHALL enter R_BURST with rd_addr=0.
REQ-026 R_BURST SHALL issue one address per cycle, 0..rlen-1, with no stalls.
REQ-027 After address rlen-1 the read FSM SHALL enter R_DRAIN for RD_LAT cycles and then R_EMPTY.
REQ-028 out_valid SHALL be the address-issue strobe delayed RD_LAT cycles; out_last SHALL mark the word for address rlen-1.
REQ-029 rd_start outside R_READY SHALL be ignored.
REQ-030 A fill and a burst SHALL proceed concurrently on opposite banks; no switch SHALL occur while in R_BURST or R_DRAIN.
REQ-031 A new fill completing while the read side is busy SHALL hold W_FULL until R_EMPTY is reached; no word SHALL be lost or overwritten.

Reset
REQ-032 While rst=1, at the next edge: the write FSM SHALL go to W_FILL with count=0; the read FSM SHALL go to R_EMPTY; the delay pipe SHALL be cleared.
REQ-033 While rst=1, all outputs SHALL be 0, including in_ready.
REQ-034 A rst asserted mid-fill or mid-burst SHALL abort the operation; data already written SHALL be discarded logically.

Configuration
REQ-035 When macro PP_BUF_CTRL_AUTO_START_EN is defined, entering R_READY SHALL start the burst in the next cycle without rd_start, and rd_start SHALL be ignored.
REQ-036 When PP_BUF_CTRL_AUTO_START_EN is undefined, bursts SHALL start only on rd_start.

Verification
REQ-037 The bench SHALL cover: len=4, 4 continuous in_valid -> wr_addr 0..3; switch high in the 5th cycle; rd_avail=1 in the 6th cycle.
REQ-038 The bench SHALL cover: rd_start with rlen=4 -> rd_addr 0..3 on 4 consecutive cycles; out_valid 2 cycles later each; out_last on the 4th word; R_EMPTY after 2 drain cycles.
REQ-039 The bench SHALL cover: second fill of 4 completing during a burst -> in_ready=0 and switch=0 until the drain ends, then a single switch pulse.
REQ-040 The bench SHALL cover: len=0 -> 256 words accepted before W_FULL; len changed 4->8 mid-fill -> fill still ends at 4.
REQ-041 The bench SHALL cover: rst during R_BURST at address 2 -> next cycle out_valid=0, rd_avail=0, in_ready=1, no switch.
REQ-042 The bench SHALL cover: with PP_BUF_CTRL_AUTO_START_EN defined and rd_start held 0 -> the burst starts 1 cycle after R_READY.
